// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between an ALU result producer, the result buffer and its consumer.
// The slave modport is the buffer's view; master is the producer/consumer view.
interface alu_result_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               ALU_Sel;
    logic [DATA_W-1:0]        ALU_Out;
    logic                     CarryOut;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               out_sel;
    logic [DATA_W-1:0]        out_result;
    logic                     out_carry;
    logic                     out_zero;
    logic [$clog2(DEPTH):0]   count;
    logic [7:0]               carry_cnt;

    modport slave (
        input  in_valid, ALU_Sel, ALU_Out, CarryOut, out_ready,
        output in_ready, out_valid, out_sel, out_result, out_carry, out_zero,
               count, carry_cnt
    );

    modport master (
        output in_valid, ALU_Sel, ALU_Out, CarryOut, out_ready,
        input  in_ready, out_valid, out_sel, out_result, out_carry, out_zero,
               count, carry_cnt
    );
endinterface

// File: rtl/alu_result_buffer.sv
// FIFO of ALU results {opcode tag, result, carry} with a saturating count of carry-set pushes.
// Head fields come straight from storage and are forced to zero whenever the buffer is empty.
module alu_result_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_result_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [3:0]        r_mem_sel   [DEPTH];
    logic [DATA_W-1:0] r_mem_data  [DEPTH];
    logic              r_mem_carry [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        r_carry_cnt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;

    assign w_in_ready  = (r_count != CNT_W'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // Storage is left uncleared by reset; the empty-buffer masking below hides stale entries.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_mem_sel[gi]   <= bus.ALU_Sel;
                    r_mem_data[gi]  <= bus.ALU_Out;
                    r_mem_carry[gi] <= bus.CarryOut;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_carry_cnt <= '0;
        end else if (w_push && bus.CarryOut && (r_carry_cnt != 8'hFF)) begin
            r_carry_cnt <= r_carry_cnt + 8'd1;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_sel    = w_out_valid ? r_mem_sel[r_rd_ptr]   : 4'h0;
    assign bus.out_result = w_out_valid ? r_mem_data[r_rd_ptr]  : '0;
    assign bus.out_carry  = w_out_valid ? r_mem_carry[r_rd_ptr] : 1'b0;
    assign bus.out_zero   = w_out_valid && (r_mem_data[r_rd_ptr] == '0);
    assign bus.count      = r_count;
    assign bus.carry_cnt  = r_carry_cnt;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed scenarios plus random traffic, checked by a
// queue-based reference model that a negedge monitor compares against the head outputs.
module tb_alu_result_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_result_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    alu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];   // {sel, data, carry}
    int m_carry = 0;
    int max_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge reset) begin
        exp_q.delete();
        m_carry = 0;
    end

    // Reference model: a FIFO of accepted results, evaluated from the values held between edges.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_carry = 0;
        end else begin
            automatic int  sz = exp_q.size();
            automatic bit  do_pop  = bus.out_ready && (sz != 0);
            automatic bit  do_push = bus.in_valid && (sz != DEPTH);
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
            chk("count", 32'(bus.count), 32'(sz));
            chk("in_ready", 32'(bus.in_ready), 32'(sz != DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(sz != 0));
            chk("carry_cnt", 32'(bus.carry_cnt), 32'(m_carry));
            if (sz == 0) begin
                chk("empty_head", {bus.out_sel, bus.out_result, bus.out_carry, bus.out_zero}, 32'h0);
            end else begin
                chk("head_fields", {bus.out_sel, bus.out_result, bus.out_carry}, 32'(exp_q[0]));
                chk("out_zero", 32'(bus.out_zero), 32'(exp_q[0][8:1] == 8'h00));
            end
            if (do_pop) begin
                $display("POP sel=%h result=%h carry=%b count=%0d", bus.out_sel, bus.out_result,
                         bus.out_carry, bus.count);
                void'(exp_q.pop_front());
            end
            if (do_push) begin
                exp_q.push_back({bus.ALU_Sel, bus.ALU_Out, bus.CarryOut});
                if (bus.CarryOut && m_carry < 255) m_carry++;
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] sel, input logic [7:0] d,
                         input logic c, input logic ordy);
        bus.in_valid  = v;
        bus.ALU_Sel   = sel;
        bus.ALU_Out   = d;
        bus.CarryOut  = c;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.count == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_done", 32'(bus.count), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.ALU_Sel = 4'h0; bus.ALU_Out = 8'h00;
        bus.CarryOut = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_outs", {bus.out_valid, bus.out_sel, bus.out_result, bus.out_carry, bus.out_zero}, 32'h0);
        chk("rst_carry_cnt", 32'(bus.carry_cnt), 32'd0);
        reset = 1'b0;

        // Single pass into an empty buffer
        drive(1'b1, 4'hF, 8'h00, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_sel", 32'(bus.out_sel), 32'hF);
        chk("single_result", 32'(bus.out_result), 32'h00);
        chk("single_zero", 32'(bus.out_zero), 32'd1);
        chk("single_count", 32'(bus.count), 32'd1);
        drain();

        // Fill, then an ignored push while full
        for (int i = 1; i <= 4; i++) drive(1'b1, 4'(i), 8'(i * 8'h11), 1'b0, 1'b0);
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 4'h5, 8'h55, 1'b0, 1'b0);
        chk("full_ignore_count", 32'(bus.count), 32'd4);
        drain();

        // Full with simultaneous push/pop: pop happens, push waits a cycle
        for (int i = 1; i <= 4; i++) drive(1'b1, 4'(i), 8'(i * 8'h11), 1'b0, 1'b0);
        drive(1'b1, 4'h6, 8'h66, 1'b1, 1'b1);
        chk("fullpp_count", 32'(bus.count), 32'd3);
        chk("fullpp_in_ready", 32'(bus.in_ready), 32'd1);
        chk("fullpp_head", 32'(bus.out_result), 32'h22);
        drive(1'b1, 4'h6, 8'h66, 1'b1, 1'b0);
        chk("fullpp_accept", 32'(bus.count), 32'd4);
        drain();

        // Continuous streaming across pointer wrap
        max_cnt = 0;
        for (int i = 0; i < 10; i++) drive(1'b1, 4'(i), 8'(i), 1'b0, 1'b1);
        drain();
        chk("wrap_max_count_le1", 32'(max_cnt <= 1), 32'd1);

        // Carry counter saturation
        for (int i = 0; i < 260; i++) drive(1'b1, 4'h2, 8'($urandom), 1'b1, 1'b1);
        drain();
        chk("carry_sat", 32'(bus.carry_cnt), 32'd255);

        // Asynchronous reset between edges with three entries held
        for (int i = 0; i < 3; i++) drive(1'b1, 4'h7, 8'(8'h30 + i), 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_count", 32'(bus.count), 32'd0);
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        chk("async_carry", 32'(bus.carry_cnt), 32'd0);
        chk("async_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 4'h9, 8'hA5, 1'b0, 1'b0);
        drive(1'b1, 4'h9, 8'h5A, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        chk("post_reset_head", 32'(bus.out_result), 32'hA5);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  1'($urandom), 1'($urandom_range(0, 2) != 0));
        drain();
        @(negedge clk);
        chk("model_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of ALU_Out and out_result.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of buffered result entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  a producer-side result is present this cycle.
REQ-006 SHALL have port in_ready  output  1  the buffer can accept a result this cycle.
REQ-007 SHALL have port ALU_Sel  input  4  opcode that produced the result; stored as tag.
REQ-008 SHALL have port ALU_Out  input  DATA_W  ALU result word.
REQ-009 SHALL have port CarryOut  input  1  ALU carry flag.
REQ-010 SHALL have port out_valid  output  1  head entry is valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-012 SHALL have port out_sel  output  4  stored opcode tag of head entry.
REQ-013 SHALL have port out_result  output  DATA_W  stored result of head entry.
REQ-014 SHALL have port out_carry  output  1  stored carry of head entry.
REQ-015 SHALL have port out_zero  output  1  high when out_result is all zeros and out_valid is high.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-017 SHALL have port carry_cnt  output  8  number of accepted entries with CarryOut=1, saturating.

Function
REQ-018 Push SHALL occur when in_valid && in_ready at a clock edge; {ALU_Sel, ALU_Out, CarryOut} written at the write pointer.
REQ-019 Pop SHALL occur when out_valid && out_ready at a clock edge; read pointer advances.
REQ-020 in_ready SHALL equal (count != DEPTH); no combinational dependence on out_ready.
REQ-021 out_valid SHALL equal (count != 0); head fields SHALL come from storage, with no bypass from inputs.
REQ-022 Latency SHALL be 1 cycle: a result pushed into an empty buffer at edge N appears with out_valid high after edge N.
REQ-023 Head fields SHALL remain stable while out_valid is high and out_ready is low.
REQ-024 Pointers SHALL wrap modulo DEPTH; ordering SHALL be strict FIFO across wrap.
REQ-025 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH-1 and count=1.
REQ-026 At count=DEPTH, in_valid SHALL be ignored (in_ready low); a pop in that cycle SHALL reduce count to DEPTH-1, with the push accepted no earlier than the next cycle.
REQ-027 At count=0 with out_ready high, no pop SHALL occur and count SHALL stay 0.
REQ-028 carry_cnt SHALL increment by 1 on each push with CarryOut=1 and SHALL hold at 255.
REQ-029 out_zero SHALL be low whenever out_valid is low.
REQ-030 Fields of non-occupied entries SHALL never reach outputs; out_sel, out_result and out_carry SHALL read 0 when out_valid is low.

Reset
REQ-031 While reset is high, state SHALL clear immediately regardless of clk: pointers=0, count=0, carry_cnt=0, out_valid=0, in_ready=1, out_sel=0, out_result=0, out_carry=0, out_zero=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries; the first push after deassertion SHALL be the first entry popped.
REQ-033 Storage array contents need not be cleared; REQ-030 masks them.

Verification
REQ-034 Single pass: push {ALU_Sel=4'b1111, ALU_Out=8'h00, CarryOut=0} with out_ready=0 -> next cycle out_valid=1, out_sel=4'hF, out_result=8'h00, out_zero=1, count=1.
REQ-035 Fill: 4 pushes (results 8'h11, 8'h22, 8'h33, 8'h44), out_ready=0 -> count=4, in_ready=0; 5th push (8'h55) is ignored; draining yields 11, 22, 33, 44 only.
REQ-036 Full push/pop: at count=4, in_valid=1 and out_ready=1 -> pops 8'h11, count=3, in_ready=1 next cycle; the push is accepted on the following edge.
REQ-037 Wrap: 10 continuous pushes with out_ready=1 throughout, results 0..9 -> outputs 0..9 in order, count never exceeds 1.
REQ-038 Carry saturation: 260 pushes with CarryOut=1, consumer draining -> carry_cnt=255.
REQ-039 Async reset: with 3 entries held, pulse reset between clock edges -> count=0, out_valid=0, carry_cnt=0 immediately; a subsequent push of 8'hA5 is popped first.
